pll_lock_ctrl: RTL

- Startup sequencer and lock monitor for the digital PLL.
- Drives the PLL's resetb, enable and div inputs.
- Measures a pre-divided PLL feedback clock against the reference oscillator and reports locked/fault status to system logic.
- Runs entirely in the osc reference-clock domain.

---
 rtl/pll_lock_ctrl_if.sv | 24 ++
 rtl/pll_lock_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl_if.sv
// Control and status bundle between system logic and the PLL lock controller.
// The master side requests operation and supplies the feedback clock; the slave reports status.
interface pll_lock_ctrl_if;
    logic       start;
    logic [4:0] div_cfg;
    logic       fb_div;
    logic       pll_resetb;
    logic       pll_enable;
    logic [4:0] pll_div;
    logic       locked;
    logic       fault;
    logic [2:0] state;
    logic [7:0] last_count;

    modport master (
        output start, div_cfg, fb_div,
        input  pll_resetb, pll_enable, pll_div, locked, fault, state, last_count
    );

    modport slave (
        input  start, div_cfg, fb_div,
        output pll_resetb, pll_enable, pll_div, locked, fault, state, last_count
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL startup sequencer and frequency-lock monitor, clocked by the reference oscillator.
// Counts synchronized fb_div rising edges over fixed windows and walks IDLE/RST/SETTLE/MEASURE/LOCKED/FAULT.
module pll_lock_ctrl #(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 256,
    parameter int WIN_CYC    = 64,
    parameter int EXP_EDGES  = 16,
    parameter int TOL        = 1,
    parameter int MAX_TRIES  = 8,
    parameter int LOSS_CNT   = 2
) (
    input  logic           osc,
    input  logic           reset,
    pll_lock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_LOCKED  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [7:0] LO_EDGES = 8'(EXP_EDGES - TOL);
    localparam logic [7:0] HI_EDGES = 8'(EXP_EDGES + TOL);

    state_t      r_state;
    logic [15:0] r_cyc;
    logic [7:0]  r_tries;
    logic [7:0]  r_miss;
    logic [7:0]  r_count;
    logic [7:0]  r_last_count;
    logic [4:0]  r_pll_div;
    logic        r_pll_resetb;
    logic        r_pll_enable;
    logic        r_locked;
    logic        r_fault;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;

    logic        w_edge;
    logic [7:0]  w_count_inc;
    logic        w_pass;
    logic        w_win_end;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge osc or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.fb_div;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // The window total includes an edge detected on the window's final cycle.
    assign w_edge      = r_sync2 & ~r_prev;
    assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'(w_edge);
    assign w_pass      = (w_count_inc >= LO_EDGES) && (w_count_inc <= HI_EDGES);
    assign w_win_end   = (r_cyc == 16'(WIN_CYC - 1));

    always_ff @(posedge osc or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_tries      <= '0;
            r_miss       <= '0;
            r_count      <= '0;
            r_last_count <= '0;
            r_pll_div    <= '0;
            r_pll_resetb <= 1'b0;
            r_pll_enable <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_count <= w_count_inc;
            if (r_state != S_IDLE && !bus.start) begin
                // Shutdown request outranks any window completing on this edge.
                r_state      <= S_IDLE;
                r_cyc        <= '0;
                r_pll_resetb <= 1'b0;
                r_pll_enable <= 1'b0;
                r_locked     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cyc        <= '0;
                        r_pll_resetb <= 1'b0;
                        r_pll_enable <= 1'b0;
                        r_locked     <= 1'b0;
                        if (bus.start) begin
                            r_pll_div <= bus.div_cfg;
                            r_tries   <= '0;
                            r_miss    <= '0;
                            r_fault   <= 1'b0;
                            r_state   <= S_RST;
                        end
                    end
                    S_RST: begin
                        if (r_cyc == 16'(RST_CYC - 1)) begin
                            r_cyc        <= '0;
                            r_count      <= '0;
                            r_pll_resetb <= 1'b1;
                            r_pll_enable <= 1'b1;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_cyc <= r_cyc + 16'd1;
                        end
                    end
                    S_SETTLE: begin
                        r_count <= '0;
                        if (r_cyc == 16'(SETTLE_CYC - 1)) begin
                            r_cyc   <= '0;
                            r_state <= S_MEASURE;
                        end else begin
                            r_cyc <= r_cyc + 16'd1;
                        end
                    end
                    S_MEASURE: begin
                        if (w_win_end) begin
                            r_cyc        <= '0;
                            r_count      <= '0;
                            r_last_count <= w_count_inc;
                            if (w_pass) begin
                                r_locked <= 1'b1;
                                r_miss   <= '0;
                                r_state  <= S_LOCKED;
                            end else if (r_tries == 8'(MAX_TRIES - 1)) begin
                                r_tries      <= r_tries + 8'd1;
                                r_fault      <= 1'b1;
                                r_pll_resetb <= 1'b0;
                                r_pll_enable <= 1'b0;
                                r_state      <= S_FAULT;
                            end else begin
                                r_tries <= r_tries + 8'd1;
                            end
                        end else begin
                            r_cyc <= r_cyc + 16'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (w_win_end) begin
                            r_cyc        <= '0;
                            r_count      <= '0;
                            r_last_count <= w_count_inc;
                            if (w_pass) begin
                                r_miss <= '0;
                            end else if (r_miss == 8'(LOSS_CNT - 1)) begin
                                r_miss       <= '0;
                                r_tries      <= '0;
                                r_locked     <= 1'b0;
                                r_pll_resetb <= 1'b0;
                                r_pll_enable <= 1'b0;
                                r_state      <= S_RST;
                            end else begin
                                r_miss <= r_miss + 8'd1;
                            end
                        end else begin
                            r_cyc <= r_cyc + 16'd1;
                        end
                    end
                    S_FAULT: begin
                        r_fault      <= 1'b1;
                        r_locked     <= 1'b0;
                        r_pll_resetb <= 1'b0;
                        r_pll_enable <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pll_resetb = r_pll_resetb;
    assign bus.pll_enable = r_pll_enable;
    assign bus.pll_div    = r_pll_div;
    assign bus.locked     = r_locked;
    assign bus.fault      = r_fault;
    assign bus.state      = r_state;
    assign bus.last_count = r_last_count;
endmodule
